// File: rtl/eth_echo_responder_if.sv
// eth_echo_responder_if: 64-bit AXI-Stream bundle (data, byte keep, last, user) used on both sides of the echo responder
interface eth_echo_responder_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_echo_responder.sv
// eth_echo_responder: buffers frames addressed to MAC_ADDR or broadcast and echoes them back with swapped MAC addresses.
// Frame counters are built only when ETH_ECHO_COUNTERS_EN is defined; otherwise they read as zero.
module eth_echo_responder #(
  parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
  parameter int          DEPTH_LOG2 = 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  eth_echo_responder_if.slave         rx_axis,
  eth_echo_responder_if.master        tx_axis,
  output logic [15:0]                 status,
  output logic [15:0]                 rx_frames,
  output logic [15:0]                 tx_frames,
  output logic [15:0]                 drop_frames
);
  localparam int AW = DEPTH_LOG2;
  localparam logic [AW:0] LAST_IDX = (AW+1)'(2**AW - 1);

  typedef enum logic [1:0] {IDLE, RECV, DROP, SEND} state_t;

  state_t      state;
  logic [63:0] mem [2**AW];
  logic [15:0] hdr_b67;
  logic [63:0] hdr1;
  logic [63:0] rd_word;
  logic [47:0] dst;
  logic [AW:0] beat, rd_idx, wcnt;
  logic [7:0]  last_keep;
  logic        drop_p, done_p;
  logic        rx_acc, tx_acc, dst_ok, too_short, go_send, rd_last;

  assign rx_axis.tready = state != SEND;
  assign rx_acc         = rx_axis.tvalid && rx_axis.tready;
  assign tx_acc         = tx_axis.tvalid && tx_axis.tready;
  assign tx_axis.tuser  = 1'b0;
  assign status         = {13'd0, done_p, drop_p, state != IDLE};
  assign dst            = {rx_axis.tdata[7:0], rx_axis.tdata[15:8], rx_axis.tdata[23:16],
                           rx_axis.tdata[31:24], rx_axis.tdata[39:32], rx_axis.tdata[47:40]};
  assign dst_ok         = dst == MAC_ADDR || dst == '1;
  assign too_short      = beat == (AW+1)'(1) && rx_axis.tkeep != 8'hFF && rx_axis.tkeep[5:0] != 6'h3F;
  assign go_send        = state == RECV && rx_acc && rx_axis.tlast && !rx_axis.tuser && !too_short;
  assign rd_last        = rd_idx == wcnt - 1'b1;
  // Words 0 and 1 are rebuilt from the header registers: new dst = old src, new src = our address.
  assign rd_word        = rd_idx == '0 ? {MAC_ADDR[39:32], MAC_ADDR[47:40], hdr1[31:0], hdr_b67}
                        : rd_idx == (AW+1)'(1) ? {hdr1[63:32], MAC_ADDR[7:0], MAC_ADDR[15:8], MAC_ADDR[23:16], MAC_ADDR[31:24]}
                        : mem[rd_idx[AW-1:0]];

  // Frame buffer: every beat of a candidate frame lands at its beat index; contents survive reset.
  always_ff @(posedge clock)
    if (rx_acc && state inside {IDLE, RECV}) mem[beat[AW-1:0]] <= rx_axis.tdata;

  // Receive / drop / send state machine with registered TX outputs and status pulses.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= IDLE;
      beat           <= '0;
      rd_idx         <= '0;
      wcnt           <= '0;
      last_keep      <= '0;
      hdr_b67        <= '0;
      hdr1           <= '0;
      drop_p         <= 1'b0;
      done_p         <= 1'b0;
      tx_axis.tvalid <= 1'b0;
      tx_axis.tlast  <= 1'b0;
      tx_axis.tdata  <= '0;
      tx_axis.tkeep  <= '0;
    end else begin
      drop_p <= 1'b0;
      done_p <= 1'b0;
      case (state)
        IDLE: if (rx_acc) begin
          hdr_b67 <= rx_axis.tdata[63:48];
          state   <= rx_axis.tlast ? IDLE : dst_ok ? RECV : DROP;
          beat    <= (AW+1)'(!rx_axis.tlast && dst_ok);
          drop_p  <= rx_axis.tlast || !dst_ok;
        end
        RECV: if (rx_acc) begin
          if (beat == (AW+1)'(1)) hdr1 <= rx_axis.tdata;
          beat      <= rx_axis.tlast || beat == LAST_IDX ? '0 : beat + 1'b1;
          wcnt      <= beat + 1'b1;
          last_keep <= rx_axis.tkeep;
          rd_idx    <= '0;
          state     <= rx_axis.tlast ? (go_send ? SEND : IDLE) : beat == LAST_IDX ? DROP : RECV;
          drop_p    <= rx_axis.tlast ? !go_send : beat == LAST_IDX;
        end
        DROP: if (rx_acc && rx_axis.tlast) state <= IDLE;
        SEND: if (tx_acc && tx_axis.tlast) begin
          state          <= IDLE;
          tx_axis.tvalid <= 1'b0;
          tx_axis.tlast  <= 1'b0;
          done_p         <= 1'b1;
        end else if (!tx_axis.tvalid || tx_axis.tready) begin
          tx_axis.tvalid <= 1'b1;
          tx_axis.tdata  <= rd_word;
          tx_axis.tlast  <= rd_last;
          tx_axis.tkeep  <= rd_last ? last_keep : 8'hFF;
          rd_idx         <= rd_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_ECHO_COUNTERS_EN
  // Frame statistics; each counter wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rx_frames   <= '0;
      tx_frames   <= '0;
      drop_frames <= '0;
    end else begin
      rx_frames   <= rx_frames + 16'(go_send);
      tx_frames   <= tx_frames + 16'(done_p);
      drop_frames <= drop_frames + 16'(drop_p);
    end
  end
`else
  assign rx_frames   = '0;
  assign tx_frames   = '0;
  assign drop_frames = '0;
`endif
endmodule
